display_scan: RTL and testbench

- Parametrised successor to the fixed 4-digit display multiplexer. Time-multiplexes NB_DISPLAYS seven-segment digits (plus decimal point) onto one shared segment bus.
- Adds a per-digit enable mask, PWM brightness control, an inter-digit blanking (anti-ghosting) interval and a frame-start pulse.
- Sits between the per-digit segment encoders and the board anode/segment pins.

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_scan_timer.sv | 50 +++++
 rtl/display_scan.sv | 94 +++++++++
 tb/tb_display_scan.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display scanner.
package display_pkg;

  localparam int MAX_WIDTH = 64;

  // Segment and anode patterns are active-low, so "off" is all ones.
  localparam logic [MAX_WIDTH-1:0] SEG_BLANK = '1;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // One bit of a one-hot-low anode vector: low only at the selected position.
  function automatic logic anode_low(input int sel, input int pos);
    return (sel != pos);
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot counter and modulo-N digit index; exposes next-state values so the
// top level can register outputs without an extra cycle of lag.
module scan_timer
  import display_pkg::*;
#(
  parameter int NB_DISPLAYS   = 8,
  parameter int PRESCALE_BITS = 14,
  parameter int DIGIT_W       = clog2(NB_DISPLAYS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [PRESCALE_BITS-1:0] cnt_next,
  output logic [DIGIT_W-1:0]       idx_next,
  output logic                     slot_start,
  output logic                     frame_tick
);

  localparam logic [PRESCALE_BITS-1:0] CNT_ONE  = PRESCALE_BITS'(1);
  localparam logic [PRESCALE_BITS-1:0] CNT_MAX  = '1;
  localparam logic [DIGIT_W-1:0]       IDX_ONE  = DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0]       LAST_IDX = DIGIT_W'(NB_DISPLAYS - 1);

  logic [PRESCALE_BITS-1:0] cnt;
  logic [DIGIT_W-1:0]       idx;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_next   = cnt + CNT_ONE;
    slot_start = (cnt == CNT_MAX);
    idx_next   = idx;
    if (slot_start) begin
      // Explicit wrap: NB_DISPLAYS need not be a power of two.
      idx_next = (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      idx        <= idx_next;
      frame_tick <= slot_start && (idx_next == '0);
    end
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexes NB_DISPLAYS seven-segment digits onto one segment bus with
// per-digit enable, PWM brightness, inter-digit blanking and a frame tick.
module display_scan
  import display_pkg::*;
#(
  parameter int NB_DISPLAYS   = 8,
  parameter int NB_SEG        = 8,
  parameter int PRESCALE_BITS = 14,
  parameter int BRIGHT_BITS   = 4,
  parameter int DEAD_CYCLES   = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NB_DISPLAYS*NB_SEG-1:0]   i_seg,
  input  logic [NB_DISPLAYS-1:0]          i_en_mask,
  input  logic [BRIGHT_BITS-1:0]          i_brightness,
  output logic [NB_SEG-1:0]               o_seg,
  output logic [NB_DISPLAYS-1:0]          o_an,
  output logic [clog2(NB_DISPLAYS)-1:0]   o_digit,
  output logic                            o_frame_tick
);

  localparam int DIGIT_W = clog2(NB_DISPLAYS);
  localparam logic [PRESCALE_BITS-1:0] DEAD_LIM = PRESCALE_BITS'(DEAD_CYCLES);
  localparam logic [NB_SEG-1:0]        BLANK    = SEG_BLANK[NB_SEG-1:0];

  typedef struct packed {
    logic [NB_SEG-1:0]      seg;
    logic                   en;
    logic [BRIGHT_BITS-1:0] bright;
  } shadow_t;

  logic [PRESCALE_BITS-1:0] cnt_next;
  logic [DIGIT_W-1:0]       idx_next;
  logic                     slot_start;

  scan_timer #(
    .NB_DISPLAYS  (NB_DISPLAYS),
    .PRESCALE_BITS(PRESCALE_BITS),
    .DIGIT_W      (DIGIT_W)
  ) u_timer (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .cnt_next  (cnt_next),
    .idx_next  (idx_next),
    .slot_start(slot_start),
    .frame_tick(o_frame_tick)
  );

  shadow_t               shadow, shadow_next;
  logic [NB_SEG-1:0]     seg_sel, seg_next;
  logic                  en_sel, lit;
  logic [NB_DISPLAYS-1:0] an_next;

  always_comb begin
    seg_sel     = BLANK;
    en_sel      = 1'b0;
    shadow_next = shadow;
    an_next     = '1;
    for (int k = 0; k < NB_DISPLAYS; k++) begin
      if (idx_next == DIGIT_W'(k)) begin
        seg_sel = i_seg[k*NB_SEG +: NB_SEG];
        en_sel  = i_en_mask[k];
      end
    end
    // Inputs are sampled only at slot start so a digit never changes mid-slot.
    if (slot_start) begin
      shadow_next = '{seg: seg_sel, en: en_sel, bright: i_brightness};
    end
    lit = (cnt_next >= DEAD_LIM) && shadow_next.en &&
          (cnt_next[PRESCALE_BITS-1 -: BRIGHT_BITS] < shadow_next.bright);
    if (lit) begin
      for (int k = 0; k < NB_DISPLAYS; k++) begin
        an_next[k] = anode_low(int'(idx_next), k);
      end
    end
    seg_next = lit ? shadow_next.seg : BLANK;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow  <= '{seg: BLANK, en: 1'b0, bright: '0};
      o_an    <= '1;
      o_seg   <= BLANK;
      o_digit <= '0;
    end else begin
      shadow  <= shadow_next;
      o_an    <= an_next;
      o_seg   <= seg_next;
      o_digit <= idx_next;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with a 16-clock slot, 2-bit brightness,
// 2 dead cycles and three digits.
module tb_display_scan;

  logic        clk;
  logic        rst_n;
  logic [23:0] i_seg;
  logic [2:0]  i_en_mask;
  logic [1:0]  i_brightness;
  logic [7:0]  o_seg;
  logic [2:0]  o_an;
  logic [1:0]  o_digit;
  logic        o_frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  display_scan #(
    .NB_DISPLAYS  (3),
    .NB_SEG       (8),
    .PRESCALE_BITS(4),
    .BRIGHT_BITS  (2),
    .DEAD_CYCLES  (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_seg       (i_seg),
    .i_en_mask   (i_en_mask),
    .i_brightness(i_brightness),
    .o_seg       (o_seg),
    .o_an        (o_an),
    .o_digit     (o_digit),
    .o_frame_tick(o_frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // cyc counts rising edges since reset release; sampling happens on the falling edge.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input int n, output int lit_an, output int lit_seg, output int ticks);
    lit_an = 0;
    lit_seg = 0;
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (o_an !== 3'b111) lit_an++;
      if (o_seg !== 8'hFF) lit_seg++;
      if (o_frame_tick === 1'b1) ticks++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int la, ls, tk;
    // digit2=C0, digit1=A4, digit0=F9
    i_seg        = 24'hC0A4F9;
    i_en_mask    = 3'b000;
    i_brightness = 2'd0;
    rst_n        = 1'b0;

    // 1. Reset state, then a blank first slot.
    repeat (5) @(negedge clk);
    check("rst an", o_an, 3'b111);
    check("rst seg", o_seg, 8'hFF);
    check("rst digit", o_digit, 0);
    check("rst tick", o_frame_tick, 0);
    i_en_mask    = 3'b111;
    i_brightness = 2'd3;
    rst_n        = 1'b1;
    cyc          = 0;
    run(15, la, ls, tk);
    check("slot0 blank an", la, 0);
    check("slot0 blank seg", ls, 0);
    check("slot0 digit", o_digit, 0);

    // 2. Full brightness, all digits enabled.
    goto(16);
    check("s1 digit", o_digit, 1);
    check("s1 dead an", o_an, 3'b111);
    check("s1 tick", o_frame_tick, 0);
    goto(18);
    check("s1 p2 an", o_an, 3'b101);
    check("s1 p2 seg", o_seg, 8'hA4);
    goto(27);
    check("s1 p11 an", o_an, 3'b101);
    goto(28);
    check("s1 p12 an", o_an, 3'b111);
    check("s1 p12 seg", o_seg, 8'hFF);
    goto(32);
    check("s2 digit", o_digit, 2);
    goto(34);
    check("s2 p2 an", o_an, 3'b011);
    check("s2 p2 seg", o_seg, 8'hC0);
    goto(47);
    check("tick before", o_frame_tick, 0);
    goto(48);
    check("s3 digit", o_digit, 0);
    check("tick at frame", o_frame_tick, 1);
    goto(49);
    check("tick after", o_frame_tick, 0);
    goto(50);
    check("s3 p2 an", o_an, 3'b110);
    check("s3 p2 seg", o_seg, 8'hF9);
    goto(63);
    run(16, la, ls, tk);
    check("s4 on cycles", la, 10);
    check("s4 digit", o_digit, 1);
    run(32, la, ls, tk);
    check("frame tick count", tk, 1);

    // 3. Brightness 2 on slot 7 (digit 1).
    i_brightness = 2'd2;
    for (int p = 0; p < 16; p++) begin
      goto(112 + p);
      if (p >= 2 && p < 8) begin
        check($sformatf("b2 an p%0d", p), o_an, 3'b101);
        check($sformatf("b2 seg p%0d", p), o_seg, 8'hA4);
      end else begin
        check($sformatf("b2 an p%0d", p), o_an, 3'b111);
        check($sformatf("b2 seg p%0d", p), o_seg, 8'hFF);
      end
    end

    // 4. Brightness 0 keeps a whole frame dark while the tick continues.
    i_brightness = 2'd0;
    run(48, la, ls, tk);
    check("b0 an lit", la, 0);
    check("b0 seg driven", ls, 0);
    check("b0 ticks", tk, 1);

    // 5. Digit 1 masked; slots 11,12,13 are digits 2,0,1.
    i_en_mask    = 3'b101;
    i_brightness = 2'd3;
    run(16, la, ls, tk);
    check("mask d2 on", la, 10);
    run(16, la, ls, tk);
    check("mask d0 on", la, 10);
    run(16, la, ls, tk);
    check("mask d1 on", la, 0);
    check("mask d1 seg", ls, 0);
    goto(229);
    check("mid p5 an", o_an, 3'b011);
    check("mid p5 seg", o_seg, 8'hC0);
    i_seg        = 24'h809992;
    i_brightness = 2'd1;
    goto(235);
    check("mid hold an", o_an, 3'b011);
    check("mid hold seg", o_seg, 8'hC0);
    goto(242);
    check("new slot an", o_an, 3'b110);
    check("new slot seg", o_seg, 8'h92);
    goto(244);
    check("b1 p4 an", o_an, 3'b111);
    i_brightness = 2'd3;

    // 6. Asynchronous reset in the middle of a lit slot.
    goto(279);
    check("pre rst an", o_an, 3'b011);
    check("pre rst seg", o_seg, 8'h80);
    #1 rst_n = 1'b0;
    #1;
    check("async an", o_an, 3'b111);
    check("async seg", o_seg, 8'hFF);
    check("async digit", o_digit, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    goto(15);
    check("restart digit", o_digit, 0);
    check("restart blank", o_an, 3'b111);
    goto(16);
    check("restart s1 digit", o_digit, 1);
    check("restart s1 tick", o_frame_tick, 0);
    goto(48);
    check("restart frame tick", o_frame_tick, 1);
    goto(50);
    check("restart d0 an", o_an, 3'b110);
    check("restart d0 seg", o_seg, 8'h92);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
